// File: rtl/camkey_loader.sv
// camkey_loader: serial loader for the 12-bit camouflage select key.
// A frame is one key_sof strobe followed by key bits on key_sdi (s_0 first),
// each qualified by key_vld. Bits collect in a shadow register. The key is
// copied to s_key in one step, one cycle after the last bit, so s_key never
// shows a partial key. lock_req freezes the committed key until RST.
//
// Handshake: key_vld is a plain per-cycle qualifier with no back-pressure.
// Every cycle with key_vld=1 in an active frame consumes exactly one bit.
//
// Build option: define CAMKEY_PARITY_EN to add a 13th even-parity bit to each
// frame. A frame with bad parity sets key_err and is discarded. With the macro
// undefined, frames are 12 bits and every completed frame is accepted.
// o_dbg_state exposes the FSM state for observation.
module camkey_loader (
  input  logic        CK,
  input  logic        RST,
  input  logic        key_sof,
  input  logic        key_vld,
  input  logic        key_sdi,
  input  logic        lock_req,
  output logic [11:0] s_key,
  output logic        key_ready,
  output logic        key_err,
  output logic        locked,
  output logic [1:0]  o_dbg_state
);

`ifdef CAMKEY_PARITY_EN
  localparam int FRAME_LEN = 13;
`else
  localparam int FRAME_LEN = 12;
`endif
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_CHECK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_count;
  logic [FRAME_LEN-1:0]  r_shadow;
  logic [11:0]           r_s_key;
  logic                  r_key_ready;
  logic                  r_key_err;

  logic                  w_lock;
  logic                  w_start;
  logic                  w_accept;
  logic [3:0]            w_idx;
  logic                  w_last;
  logic                  w_good;
  logic                  w_commit;
  logic                  w_err_set;
  logic [FRAME_LEN-1:0]  w_shadow_next;
  logic [3:0]            w_count_next;

  // Decode the events of this cycle: lock, frame start/restart, bit accept.
  always_comb begin
    w_lock   = lock_req && r_key_ready &&
               (r_state == ST_IDLE || r_state == ST_CHECK);
    // A lock in IDLE takes priority over a simultaneous start of frame.
    w_start  = key_sof && ((r_state == ST_IDLE && !w_lock) || r_state == ST_SHIFT);
    w_accept = key_vld && (w_start || r_state == ST_SHIFT);
    w_idx    = w_start ? 4'd0 : r_count;
    w_last   = w_accept && (w_idx == LAST_IDX);
`ifdef CAMKEY_PARITY_EN
    w_good   = ~(^r_shadow);
`else
    w_good   = 1'b1;
`endif
    w_commit  = (r_state == ST_CHECK) && w_good;
    w_err_set = (key_sof && (r_state == ST_SHIFT || r_state == ST_LOCKED)) ||
                ((r_state == ST_CHECK) && !w_good);
  end

  // Next shadow/count: a start clears both, and an accepted bit lands at w_idx.
  always_comb begin
    w_shadow_next = w_start ? '0 : r_shadow;
    w_count_next  = w_start ? 4'd0 : r_count;
    if (w_accept) begin
      w_shadow_next[w_idx] = key_sdi;
      w_count_next         = 4'(w_idx + 4'd1);
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_lock)       w_next = ST_LOCKED;
        else if (w_start) w_next = w_last ? ST_CHECK : ST_SHIFT;
      end
      ST_SHIFT:  if (w_last) w_next = ST_CHECK;
      ST_CHECK:  w_next = w_lock ? ST_LOCKED : ST_IDLE;
      ST_LOCKED: w_next = ST_LOCKED;
      default:   w_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Datapath: shadow capture, atomic key commit and sticky flags.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_shadow    <= '0;
      r_count     <= 4'd0;
      r_s_key     <= 12'h000;
      r_key_ready <= 1'b0;
      r_key_err   <= 1'b0;
    end else begin
      if (w_start || w_accept) begin
        r_shadow <= w_shadow_next;
        r_count  <= w_count_next;
      end else if ((r_state == ST_CHECK) && !w_good) begin
        r_shadow <= '0;
      end
      if (w_commit) begin
        r_s_key     <= r_shadow[11:0];
        r_key_ready <= 1'b1;
      end
      if (w_err_set) r_key_err <= 1'b1;
    end
  end

  assign s_key       = r_s_key;
  assign key_ready   = r_key_ready;
  assign key_err     = r_key_err;
  assign locked      = (r_state == ST_LOCKED);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_camkey_loader.sv
// tb_camkey_loader: table-driven frame vectors, hand-written corner sequences
// and a randomized run against a frame-level reference model.
module tb_camkey_loader;

`ifdef CAMKEY_PARITY_EN
  localparam int FRAME_LEN = 13;
`else
  localparam int FRAME_LEN = 12;
`endif

  logic        CK;
  logic        RST;
  logic        key_sof;
  logic        key_vld;
  logic        key_sdi;
  logic        lock_req;
  logic [11:0] s_key;
  logic        key_ready;
  logic        key_err;
  logic        locked;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  camkey_loader dut (
    .CK          (CK),
    .RST         (RST),
    .key_sof     (key_sof),
    .key_vld     (key_vld),
    .key_sdi     (key_sdi),
    .lock_req    (lock_req),
    .s_key       (s_key),
    .key_ready   (key_ready),
    .key_err     (key_err),
    .locked      (locked),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  // ---------------- reference model ----------------
  // Frame-level view: a list of received bits, a pending-commit flag and the
  // visible outputs.
  bit          model_on = 1'b0;
  bit          m_in_frame;
  bit          m_pending;
  bit          m_bits[$];
  logic [11:0] m_skey;
  bit          m_ready;
  bit          m_err;
  bit          m_locked;
  logic [14:0] exp_q[$];

  function automatic void m_reset();
    m_in_frame = 0;
    m_pending  = 0;
    m_bits.delete();
    m_skey     = 12'h000;
    m_ready    = 0;
    m_err      = 0;
    m_locked   = 0;
  endfunction

  function automatic void m_step(input bit sof, input bit vld, input bit sdi, input bit lck);
    logic [11:0] data;
    bit          good;
    if (m_locked) begin
      if (sof) m_err = 1;
    end else if (m_pending) begin
      data = '0;
      for (int i = 0; i < 12; i++) data[i] = m_bits[i];
      good = (FRAME_LEN == 12) ? 1'b1 : ((^data) == m_bits[12]);
      if (lck && m_ready) m_locked = 1;
      if (good) begin
        m_skey  = data;
        m_ready = 1;
      end else begin
        m_err = 1;
      end
      m_pending = 0;
      m_bits.delete();
    end else if (!m_in_frame) begin
      if (lck && m_ready) m_locked = 1;
      else if (sof) begin
        m_in_frame = 1;
        m_bits.delete();
        if (vld) m_bits.push_back(sdi);
      end
    end else begin
      if (sof) begin
        m_err = 1;
        m_bits.delete();
      end
      if (vld) m_bits.push_back(sdi);
      if (m_bits.size() == FRAME_LEN) begin
        m_in_frame = 0;
        m_pending  = 1;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the negedge, step the model at the posedge,
  // compare at the following negedge.
  task automatic cyc(input bit sof, input bit vld, input bit sdi, input bit lck);
    logic [14:0] e;
    key_sof  = sof;
    key_vld  = vld;
    key_sdi  = sdi;
    lock_req = lck;
    @(posedge CK);
    if (model_on) begin
      m_step(sof, vld, sdi, lck);
      exp_q.push_back({m_skey, m_ready, m_err, m_locked});
    end
    @(negedge CK);
    key_sof  = 0;
    key_vld  = 0;
    key_sdi  = 0;
    lock_req = 0;
    if (model_on) begin
      e = exp_q.pop_front();
      chk("rand_outputs", {1'b0, s_key, key_ready, key_err, locked}, {1'b0, e});
    end
  endtask

  task automatic do_reset();
    @(negedge CK);
    RST      = 1;
    key_sof  = 0;
    key_vld  = 0;
    key_sdi  = 0;
    lock_req = 0;
    @(negedge CK);
    @(negedge CK);
    RST = 0;
    if (model_on) m_reset();
  endtask

  function automatic bit frame_bit(input logic [11:0] key, input int i, input bit bad_par);
    if (i < 12) return key[i];
    return (^key) ^ bad_par;
  endfunction

  // Sof cycle, optional aborted prefix, then a full frame. s_key must keep
  // hold_key through every bit, including the last one.
  task automatic send_frame(input logic [11:0] key, input int gap_at, input int gap_len,
                            input int abort_at, input bit bad_par, input logic [11:0] hold_key);
    logic [11:0] junk;
    junk = 12'hABC;
    cyc(1, 0, 0, 0);
    if (abort_at > 0) begin
      for (int i = 0; i < abort_at; i++) cyc(0, 1, junk[i], 0);
      cyc(1, 0, 0, 0);
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      cyc(0, 1, frame_bit(key, i, bad_par), 0);
      chk("hold_during_frame", {4'h0, s_key}, {4'h0, hold_key});
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          cyc(0, 0, 1'($urandom_range(0, 1)), 0);
          chk("hold_during_gap", {4'h0, s_key}, {4'h0, hold_key});
        end
      end
    end
  endtask

  task automatic chk_outputs(input string nm, input logic [11:0] k, input bit r, input bit e, input bit l);
    chk(nm, {1'b0, s_key, key_ready, key_err, locked}, {1'b0, k, r, e, l});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       nm;
    logic [11:0] key;
    int          gap_at;
    int          gap_len;
    int          abort_at;
    bit          bad_par;
    logic [11:0] exp_key;
    bit          exp_ready;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  // ---------------- test sequence ----------------
  initial begin
    RST = 1; key_sof = 0; key_vld = 0; key_sdi = 0; lock_req = 0;

    vecs.push_back('{"e4d_plain",   12'hE4D, -1, 0, 0, 0, 12'hE4D, 1, 0});
    vecs.push_back('{"e4d_gap",     12'hE4D,  5, 3, 0, 0, 12'hE4D, 1, 0});
    vecs.push_back('{"abort_0a5",   12'h0A5, -1, 0, 7, 0, 12'h0A5, 1, 1});
    vecs.push_back('{"all_ones",    12'hFFF, -1, 0, 0, 0, 12'hFFF, 1, 0});
    vecs.push_back('{"all_zero",    12'h000,  0, 2, 0, 0, 12'h000, 1, 0});
    vecs.push_back('{"abort_early", 12'h5A3,  3, 1, 1, 0, 12'h5A3, 1, 1});
`ifdef CAMKEY_PARITY_EN
    vecs.push_back('{"par_bad",     12'h001, -1, 0, 0, 1, 12'h000, 0, 1});
    vecs.push_back('{"par_good",    12'h001, -1, 0, 0, 0, 12'h001, 1, 0});
`endif

    // Table-driven frames, each from a fresh reset.
    for (int v = 0; v < vecs.size(); v++) begin
      do_reset();
      chk_outputs({vecs[v].nm, "_reset"}, 12'h000, 0, 0, 0);
      send_frame(vecs[v].key, vecs[v].gap_at, vecs[v].gap_len, vecs[v].abort_at,
                 vecs[v].bad_par, 12'h000);
      cyc(0, 0, 0, 0);
      chk_outputs(vecs[v].nm, vecs[v].exp_key, vecs[v].exp_ready, vecs[v].exp_err, 0);
    end

    // Lock: ignored before ready, then freezes 3C3 against a later frame.
    do_reset();
    cyc(0, 0, 0, 1);
    chk_outputs("lock_before_ready", 12'h000, 0, 0, 0);
    send_frame(12'h3C3, -1, 0, 0, 0, 12'h000);
    cyc(0, 0, 0, 0);
    chk_outputs("commit_3c3", 12'h3C3, 1, 0, 0);
    cyc(0, 0, 0, 1);
    chk_outputs("lock_set", 12'h3C3, 1, 0, 1);
    send_frame(12'hFFF, -1, 0, 0, 0, 12'h3C3);
    cyc(0, 0, 0, 0);
    chk_outputs("locked_frame_fff", 12'h3C3, 1, 1, 1);

    // vld without sof in IDLE is ignored; sof+vld accepts bit 0.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0);
    chk_outputs("idle_vld_ignored", 12'h000, 0, 0, 0);
    begin
      logic [11:0] k;
      k = 12'h9B6;
      cyc(1, 1, frame_bit(k, 0, 0), 0);
      for (int i = 1; i < FRAME_LEN; i++) cyc(0, 1, frame_bit(k, i, 0), 0);
      chk_outputs("sofvld_before_commit", 12'h000, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk_outputs("sofvld_commit", 12'h9B6, 1, 0, 0);
    end

    // Reset mid-frame clears everything asynchronously.
    do_reset();
    send_frame(12'h0A5, -1, 0, 0, 0, 12'h000);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0);
    cyc(1, 0, 0, 0);
    chk_outputs("pre_async_reset", 12'h0A5, 1, 1, 0);
    RST = 1;
    #1;
    chk_outputs("async_reset", 12'h000, 0, 0, 0);
    chk("async_reset_state", {14'h0, dbg_state}, 16'h0);
    @(negedge CK);
    RST = 0;
    send_frame(12'hE4D, -1, 0, 0, 0, 12'h000);
    cyc(0, 0, 0, 0);
    chk_outputs("after_reset_frame", 12'hE4D, 1, 0, 0);

`ifdef CAMKEY_PARITY_EN
    // Bad parity leaves the committed key alone; the good frame then loads.
    do_reset();
    send_frame(12'h7E1, -1, 0, 0, 0, 12'h000);
    cyc(0, 0, 0, 0);
    send_frame(12'h001, -1, 0, 0, 1, 12'h7E1);
    cyc(0, 0, 0, 0);
    chk_outputs("par_bad_keeps", 12'h7E1, 1, 1, 0);
    send_frame(12'h001, -1, 0, 0, 0, 12'h7E1);
    cyc(0, 0, 0, 0);
    chk_outputs("par_good_loads", 12'h001, 1, 1, 0);
`endif

    // Randomized traffic against the reference model.
    model_on = 1;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        cyc(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 149) == 0));
      end
    end
    model_on = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
